// File: rtl/gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register word indices
// and the byte-strobe to bit-mask expansion used by every write path.
package gpio_pkg;

    localparam logic [3:0] REG_OUT     = 4'd0;
    localparam logic [3:0] REG_OE      = 4'd1;
    localparam logic [3:0] REG_IN      = 4'd2;
    localparam logic [3:0] REG_SET     = 4'd3;
    localparam logic [3:0] REG_CLR     = 4'd4;
    localparam logic [3:0] REG_TGL     = 4'd5;
    localparam logic [3:0] REG_RISE_EN = 4'd6;
    localparam logic [3:0] REG_FALL_EN = 4'd7;
    localparam logic [3:0] REG_PEND    = 4'd8;

    // Each strobe bit covers one byte lane of the 32-bit bus word.
    function automatic logic [31:0] strbToMask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoSoC iomem bus bundle. The CPU side is the master; peripherals take
// the slave view and answer with a single-cycle ready pulse.
interface iomem_gpio_if;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser followed by a one-cycle history register.
// Edge vectors are formed from the synchronised value only, so they are
// safe to combine with register state in the clock domain.
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Shift the raw pins through the flop chain, then remember last value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/iomem_gpio.sv
// Memory-mapped GPIO for the PicoSoC iomem bus: output data and enable
// registers, atomic set/clear/toggle, synchronised input readback and
// per-pin edge interrupts summarised onto one level irq line.
module iomem_gpio
    import gpio_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    iomem_gpio_if.slave      bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_riseEn;
    logic [WIDTH-1:0] r_fallEn;
    logic [WIDTH-1:0] r_pend;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [3:0]       w_idx;
    logic             w_accept;
    logic             w_write;
    logic [31:0]      w_mask32;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_maskedData;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_readVal;
    logic             w_unused;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_syncEdge (
        .clk    (clk),
        .resetn (resetn),
        .i_in   (gpio_in),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // The ready pulse itself blocks acceptance, giving one access per two cycles.
    assign w_idx        = bus.iomem_addr[5:2];
    assign w_accept     = bus.iomem_valid && !r_ready && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign w_write      = w_accept && (bus.iomem_wstrb != 4'b0000);
    assign w_mask32     = strbToMask(bus.iomem_wstrb);
    assign w_mask       = w_mask32[WIDTH-1:0];
    assign w_data       = bus.iomem_wdata[WIDTH-1:0];
    assign w_maskedData = w_data & w_mask;
    assign w_w1c        = (w_write && (w_idx == REG_PEND)) ? w_maskedData : '0;

    // Bits above WIDTH, the low address bits and unused decode bits are ignored.
    assign w_unused = ^{bus.iomem_addr[23:6], bus.iomem_addr[1:0], bus.iomem_wdata, w_mask32};

    // Read mux returns the register value as it stands before any write lands.
    always_comb begin
        w_readVal = '0;
        case (w_idx)
            REG_OUT:     w_readVal[WIDTH-1:0] = r_out;
            REG_OE:      w_readVal[WIDTH-1:0] = r_oe;
            REG_IN:      w_readVal[WIDTH-1:0] = w_sync;
            REG_RISE_EN: w_readVal[WIDTH-1:0] = r_riseEn;
            REG_FALL_EN: w_readVal[WIDTH-1:0] = r_fallEn;
            REG_PEND:    w_readVal[WIDTH-1:0] = r_pend;
            default:     w_readVal = '0;
        endcase
    end

    // Bus response: one-cycle ready with data captured at acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_accept;
            if (w_accept) begin
                r_rdata <= w_readVal;
            end
        end
    end

    // Output data register with plain, set, clear and toggle write views.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out <= '0;
        end else if (w_write) begin
            case (w_idx)
                REG_OUT: r_out <= (r_out & ~w_mask) | w_maskedData;
                REG_SET: r_out <= r_out | w_maskedData;
                REG_CLR: r_out <= r_out & ~w_maskedData;
                REG_TGL: r_out <= r_out ^ w_maskedData;
                default: r_out <= r_out;
            endcase
        end
    end

    // Byte-masked configuration registers: output enable and edge enables.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_oe     <= '0;
            r_riseEn <= '0;
            r_fallEn <= '0;
        end else if (w_write) begin
            case (w_idx)
                REG_OE:      r_oe     <= (r_oe & ~w_mask) | w_maskedData;
                REG_RISE_EN: r_riseEn <= (r_riseEn & ~w_mask) | w_maskedData;
                REG_FALL_EN: r_fallEn <= (r_fallEn & ~w_mask) | w_maskedData;
                default: begin
                    r_oe     <= r_oe;
                    r_riseEn <= r_riseEn;
                    r_fallEn <= r_fallEn;
                end
            endcase
        end
    end

    // Pending edges latch every cycle; a new edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_w1c) | (w_rise & r_riseEn) | (w_fall & r_fallEn);
            r_irq  <= |r_pend;
        end
    end

    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;
    assign gpio_out        = r_out;
    assign gpio_oe         = r_oe;
    assign irq             = r_irq;

endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio at WIDTH=8: directed register, handshake and edge
// scenarios followed by randomised traffic against a register-level model.
module tb_iomem_gpio;

    localparam int          WIDTH = 8;
    localparam logic [7:0]  BASE  = 8'h03;
    localparam int          SYNC  = 2;
    localparam logic [31:0] WMASK = 32'h0000_00FF;

    logic             clk = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] m_out, m_oe, m_in, m_rise, m_fall, m_pend;

    iomem_gpio_if bus ();

    iomem_gpio #(
        .WIDTH       (WIDTH),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickN(input int n);
        repeat (n) tick();
    endtask

    // One access: present request, sample one cycle later, release, sample again.
    task automatic busAccess(input logic [3:0] idx, input logic [3:0] strb, input logic [31:0] data,
                             output logic [31:0] rdata, output logic readyAt, output logic readyAfter,
                             output logic [WIDTH-1:0] outAtReady);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {BASE, 18'h0, idx, 2'b00};
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = data;
        tick();
        readyAt    = bus.iomem_ready;
        rdata      = bus.iomem_rdata;
        outAtReady = gpio_out;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
        readyAfter = bus.iomem_ready;
    endtask

    // Register-level view: returns the pre-write value and applies the write.
    task automatic modelAccess(input logic [3:0] idx, input logic [3:0] strb, input logic [31:0] data,
                               output logic [31:0] expRead);
        logic [31:0] m, d;
        case (idx)
            4'd0:    expRead = m_out;
            4'd1:    expRead = m_oe;
            4'd2:    expRead = m_in;
            4'd6:    expRead = m_rise;
            4'd7:    expRead = m_fall;
            4'd8:    expRead = m_pend;
            default: expRead = 32'h0;
        endcase
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
        m = m & WMASK;
        d = data & m;
        if (strb != 4'h0) begin
            case (idx)
                4'd0: m_out  = (m_out & ~m) | d;
                4'd1: m_oe   = (m_oe & ~m) | d;
                4'd3: m_out  = m_out | d;
                4'd4: m_out  = m_out & ~d;
                4'd5: m_out  = m_out ^ d;
                4'd6: m_rise = (m_rise & ~m) | d;
                4'd7: m_fall = (m_fall & ~m) | d;
                4'd8: m_pend = m_pend & ~d;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        testsRun++; if (gpio_out !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out: got %h expected 00", gpio_out); end
        testsRun++; if (gpio_oe !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_oe: got %h expected 00", gpio_oe); end
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        testsRun++; if (bus.iomem_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.iomem_ready); end
        for (int i = 0; i < 16; i++) begin
            busAccess(4'(i), 4'h0, 32'h0, rd, ra, rf, oa);
            testsRun++; if (rd !== 32'h0 || ra !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_read idx%0d: got %h ready %b expected 0 ready 1", i, rd, ra); end
        end
    endtask

    task automatic test_out_rw();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        busAccess(4'd0, 4'hF, 32'h0000_00A5, rd, ra, rf, oa);
        testsRun++; if (oa !== 8'hA5) begin testsFailed++; $display("[TB] FAIL out_write: got %h expected a5", oa); end
        testsRun++; if (ra !== 1'b1 || rf !== 1'b0) begin testsFailed++; $display("[TB] FAIL out_ready: got %b%b expected 10", ra, rf); end
        busAccess(4'd0, 4'hF, 32'hFFFF_FFA5, rd, ra, rf, oa);
        busAccess(4'd0, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h0000_00A5) begin testsFailed++; $display("[TB] FAIL out_read: got %h expected 000000a5", rd); end
    endtask

    task automatic test_set_clr_tgl();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        logic [3:0]  idxs [3];
        logic [31:0] dats [3];
        logic [7:0]  exps [3];
        idxs = '{4'd3, 4'd4, 4'd5};
        dats = '{32'h0F, 32'h81, 32'hFF};
        exps = '{8'hAF, 8'h2E, 8'hD1};
        for (int i = 0; i < 3; i++) begin
            busAccess(idxs[i], 4'hF, dats[i], rd, ra, rf, oa);
            testsRun++; if (oa !== exps[i]) begin testsFailed++; $display("[TB] FAIL atomic_%0d: got %h expected %h", i, oa, exps[i]); end
            testsRun++; if (ra !== 1'b1 || rf !== 1'b0) begin testsFailed++; $display("[TB] FAIL atomic_ready_%0d: got %b%b expected 10", i, ra, rf); end
            testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL atomic_rdata_%0d: got %h expected 0", i, rd); end
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        busAccess(4'd1, 4'b0001, 32'h1234_5678, rd, ra, rf, oa);
        testsRun++; if (gpio_oe !== 8'h78) begin testsFailed++; $display("[TB] FAIL oe_bytemask: got %h expected 78", gpio_oe); end
        busAccess(4'd12, 4'hF, 32'hFFFF_FFFF, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h0 || ra !== 1'b1) begin testsFailed++; $display("[TB] FAIL idx12_read: got %h ready %b expected 0 ready 1", rd, ra); end
        testsRun++; if (gpio_out !== 8'hD1 || gpio_oe !== 8'h78) begin testsFailed++; $display("[TB] FAIL idx12_nochange: got out %h oe %h expected d1 78", gpio_out, gpio_oe); end
        busAccess(4'd6, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL idx12_riseen: got %h expected 0", rd); end
    endtask

    task automatic test_addr_decode();
        logic sawReady;
        sawReady = 1'b0;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {8'h04, 24'h0};
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.iomem_ready) sawReady = 1'b1;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
        testsRun++; if (sawReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL nomatch_ready: got %b expected 0", sawReady); end
        testsRun++; if (gpio_out !== 8'hD1) begin testsFailed++; $display("[TB] FAIL nomatch_out: got %h expected d1", gpio_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pattern;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {BASE, 18'h0, 4'd5, 2'b00};
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'h01;
        for (int k = 0; k < 4; k++) begin
            tick();
            pattern[3-k] = bus.iomem_ready;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
        testsRun++; if (pattern !== 4'b1010) begin testsFailed++; $display("[TB] FAIL b2b_ready: got %b expected 1010", pattern); end
        testsRun++; if (gpio_out !== 8'hD1) begin testsFailed++; $display("[TB] FAIL b2b_out: got %h expected d1", gpio_out); end
    endtask

    task automatic test_edges();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        busAccess(4'd6, 4'hF, 32'h01, rd, ra, rf, oa);
        busAccess(4'd7, 4'hF, 32'h02, rd, ra, rf, oa);
        gpio_in = 8'h03;
        tickN(3);
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL edge_irq_early: got %b expected 0", irq); end
        tick();
        testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL edge_irq_set: got %b expected 1", irq); end
        busAccess(4'd2, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h03) begin testsFailed++; $display("[TB] FAIL edge_in: got %h expected 03", rd); end
        busAccess(4'd8, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h01) begin testsFailed++; $display("[TB] FAIL edge_pend_rise: got %h expected 01", rd); end
        gpio_in = 8'h00;
        tickN(4);
        busAccess(4'd8, 4'hF, 32'h01, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h03) begin testsFailed++; $display("[TB] FAIL edge_pend_fall: got %h expected 03", rd); end
        testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL edge_irq_hold: got %b expected 1", irq); end
        busAccess(4'd8, 4'hF, 32'h02, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h02) begin testsFailed++; $display("[TB] FAIL edge_pend_w1c: got %h expected 02", rd); end
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL edge_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_clear_vs_set();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        gpio_in = 8'h01;
        tickN(4);
        gpio_in = 8'h00;
        tickN(4);
        gpio_in = 8'h01;
        tickN(2);
        busAccess(4'd8, 4'hF, 32'h01, rd, ra, rf, oa);
        busAccess(4'd8, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h01) begin testsFailed++; $display("[TB] FAIL set_beats_clear: got %h expected 01", rd); end
        busAccess(4'd8, 4'hF, 32'h01, rd, ra, rf, oa);
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL set_beats_clear_irq: got %b expected 0", irq); end
    endtask

    task automatic test_reset_midaccess();
        logic [31:0] rd; logic ra, rf; logic [WIDTH-1:0] oa;
        logic sawReady;
        busAccess(4'd0, 4'hF, 32'hFF, rd, ra, rf, oa);
        gpio_in = 8'h00; tickN(4);
        gpio_in = 8'h03; tickN(4);
        gpio_in = 8'h00; tickN(4);
        gpio_in = 8'hFF; tickN(4);
        busAccess(4'd8, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h03) begin testsFailed++; $display("[TB] FAIL prereset_pend: got %h expected 03", rd); end
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {BASE, 18'h0, 4'd0, 2'b00};
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'h5A;
        resetn = 1'b0;
        tick();
        sawReady = bus.iomem_ready;
        resetn = 1'b1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
        sawReady = sawReady | bus.iomem_ready;
        testsRun++; if (sawReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_drop_ready: got %b expected 0", sawReady); end
        testsRun++; if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_outputs: got out %h oe %h irq %b expected 00 00 0", gpio_out, gpio_oe, irq); end
        tickN(4);
        busAccess(4'd8, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_pend: got %h expected 0", rd); end
        busAccess(4'd2, 4'h0, 32'h0, rd, ra, rf, oa);
        testsRun++; if (rd !== 32'hFF) begin testsFailed++; $display("[TB] FAIL reset_in: got %h expected ff", rd); end
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq_after: got %b expected 0", irq); end
        m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_in = 32'hFF;
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, exp, data; logic ra, rf; logic [WIDTH-1:0] oa;
        logic [3:0] idx, strb;
        for (int n = 0; n < 40; n++) begin
            idx  = 4'($urandom_range(0, 15));
            strb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            data = $urandom;
            busAccess(idx, strb, data, rd, ra, rf, oa);
            modelAccess(idx, strb, data, exp);
            testsRun++; if (rd !== exp || ra !== 1'b1) begin testsFailed++; $display("[TB] FAIL rand_read idx%0d strb%h: got %h ready %b expected %h ready 1", idx, strb, rd, ra, exp); end
            testsRun++; if (gpio_out !== m_out[7:0] || gpio_oe !== m_oe[7:0]) begin testsFailed++; $display("[TB] FAIL rand_pins: got out %h oe %h expected %h %h", gpio_out, gpio_oe, m_out[7:0], m_oe[7:0]); end
            testsRun++; if (irq !== (m_pend != 0)) begin testsFailed++; $display("[TB] FAIL rand_irq: got %b expected %b", irq, m_pend != 0); end
        end
    endtask

    task automatic test_random_edges();
        logic [31:0] rd, exp, newIn; logic ra, rf; logic [WIDTH-1:0] oa;
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 0) begin
                busAccess(4'd6, 4'hF, $urandom, rd, ra, rf, oa);
                modelAccess(4'd6, 4'hF, {24'h0, 8'(rd)}, exp);
                m_rise = 32'h0;
            end
            if (n % 6 == 0) begin
                m_rise = 32'($urandom_range(0, 255));
                busAccess(4'd6, 4'hF, m_rise, rd, ra, rf, oa);
                m_fall = 32'($urandom_range(0, 255));
                busAccess(4'd7, 4'hF, m_fall, rd, ra, rf, oa);
            end
            newIn = 32'($urandom_range(0, 255));
            gpio_in = newIn[7:0];
            tickN(SYNC + 2);
            m_pend = (m_pend | ((newIn & ~m_in) & m_rise) | ((~newIn & m_in) & m_fall)) & WMASK;
            m_in = newIn;
            busAccess(4'd8, 4'h0, 32'h0, rd, ra, rf, oa);
            modelAccess(4'd8, 4'h0, 32'h0, exp);
            testsRun++; if (rd !== exp) begin testsFailed++; $display("[TB] FAIL rand_pend %0d: got %h expected %h", n, rd, exp); end
            testsRun++; if (irq !== (m_pend != 0)) begin testsFailed++; $display("[TB] FAIL rand_edge_irq %0d: got %b expected %b", n, irq, m_pend != 0); end
            if (n % 3 == 2) begin
                newIn = $urandom;
                busAccess(4'd8, 4'hF, newIn, rd, ra, rf, oa);
                modelAccess(4'd8, 4'hF, newIn, exp);
                testsRun++; if (rd !== exp) begin testsFailed++; $display("[TB] FAIL rand_w1c %0d: got %h expected %h", n, rd, exp); end
            end
        end
    endtask

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        gpio_in = '0;
        resetn  = 1'b0;
        m_out = 0; m_oe = 0; m_in = 0; m_rise = 0; m_fall = 0; m_pend = 0;
        tickN(3);
        resetn = 1'b1;
        tick();
        test_reset();
        test_out_rw();
        test_set_clr_tgl();
        test_byte_mask();
        test_addr_decode();
        test_back_to_back();
        test_edges();
        test_clear_vs_set();
        test_reset_midaccess();
        test_random_regs();
        test_random_edges();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
